tick_gen: RTL and testbench
===========================

Name: tick_gen

Overview:
- Parametrised multi-channel tick and clock-enable generator.
- Replaces the fixed compile-time RTC divider and UART bit-period constants with runtime-programmable dividers.
- Sits beside clint/uart. Channel 0 drives the RTC tick; channel 1 drives the UART bit tick; remaining channels are free for timers and peripherals.
- Programmed by a simple register-write port from the bus decoder.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- DIV_WIDTH, 24, width of each divider and counter.
- FRAC_WIDTH, 8, width of the fractional increment (used only with TICK_GEN_FRAC_EN).
- DEF_DIV0, 380, reset divider of channel 0 (RTC half-period: 25 MHz / 32768 / 2 - 1).
- DEF_DIV1, 216, reset divider of channel 1 (115200 baud: 25 MHz / 115200 - 1).
- DEF_EN, 4'b0011, per-channel enable at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- cfg_we  in  1  write strobe, one cycle
- cfg_sel  in  $clog2(CHANNELS)  channel index for write and readback
- cfg_en  in  1  enable value written
- cfg_div  in  DIV_WIDTH  divider value written
- cfg_frac  in  FRAC_WIDTH  fractional increment written
- sync  in  1  restart all enabled counters
- rd_data  out  1+DIV_WIDTH+FRAC_WIDTH  registered {en,div,frac} of channel cfg_sel
- tick  out  CHANNELS  one-cycle pulse per channel period
- tclk  out  CHANNELS  square wave, toggles on each tick

Behaviour:
- Reset, synchronous, checked at the clock edge:
  - div0 = DEF_DIV0; div1 = DEF_DIV1; all other div = 0.
  - en = DEF_EN; all counters = 0; frac and acc = 0.
  - tick = 0; tclk = 0; rd_data = 0.
  - Reset mid-period aborts the period. No tick is emitted on the reset edge.
- Per-channel counting, evaluated at each edge for an enabled channel:
  - If cnt == div: cnt <= 0, tick <= 1, tclk <= ~tclk.
  - Else: cnt <= cnt + 1, tick <= 0.
  - Period = div + 1 cycles. Tick high for exactly one cycle. tclk period = 2*(div+1).
- div = 0: tick is high every cycle and tclk toggles every cycle.
- Disabled channel: cnt <= 0, tick <= 0, tclk holds its last value.
- Write (cfg_we = 1):
  - At that edge, channel cfg_sel loads en, div and frac, and clears cnt and acc. tick <= 0 on that edge.
  - First tick is registered div+1 edges after the write edge.
  - tclk is not reset by a write.
- sync = 1: at that edge every enabled channel sets cnt <= 0 and acc <= 0, tick <= 0. Channels stay phase-aligned afterwards if their dividers are equal.
- Simultaneous write and sync: the write applies to cfg_sel; sync applies to all other channels. Both clear the counter, so there is no conflict.
- cfg_sel >= CHANNELS: the write is ignored and rd_data returns 0.
- Readback:
  - rd_data <= channel[cfg_sel] each cycle, one cycle latency.
  - Readback in the cycle after a write returns the new values.
- Counter arithmetic is unsigned DIV_WIDTH. cnt never exceeds div, so there is no wrap. The == compare guarantees recovery if div is lowered below cnt by a write, because the write clears cnt.

Optional Feature:
- Macro: TICK_GEN_FRAC_EN.
- With the macro:
  - Each channel holds frac and an accumulator acc of FRAC_WIDTH bits.
  - At every tick, {carry, acc} <= acc + frac.
  - When carry = 1, the next period compares against div+1 instead of div, so the period is div+1+carry.
  - Average period = div + 1 + frac/2^FRAC_WIDTH.
- Without the macro:
  - cfg_frac is ignored, the frac field of rd_data reads 0, and no accumulator is built.
  - Period is exactly div + 1.

Test Plan:
- Release reset, hold 2000 cycles -> ch0 tick every 381 cycles, ch0 tclk period 762; ch1 tick every 217 cycles; ch2 and ch3 tick = 0, tclk = 0.
- Write ch2 en=1 div=0 -> tick[2] high every cycle starting 1 cycle after the write edge; tclk[2] alternates 0/1.
- Write ch3 en=1 div=9, wait 25 cycles, assert sync with cfg_we=0 -> tick[3] at write+10 and write+20, then the next tick is 10 cycles after the sync edge.
- Write ch1 div=216 while cnt=150 -> no tick at old phase, next tick exactly 217 cycles after the write; rd_data reads {1,216,0} one cycle after cfg_sel=1.
- Assert reset for 1 cycle mid-period on all channels -> tick = 0, tclk = 0 next cycle, defaults restored, ch0 first tick 381 cycles after reset release.
- TICK_GEN_FRAC_EN: ch1 div=216 frac=0x02 (FRAC_WIDTH=8) -> over 128 ticks, exactly one period of 218 cycles, others 217; total 27777 cycles.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: runtime-programmable multi-channel tick and clock-enable generator.
// Channel 0 feeds the RTC tick, channel 1 the UART bit tick; the rest are free.
// Each enabled channel emits a one-cycle tick every div+1 cycles and a square
// wave (tclk) that toggles on every tick.
// Optional feature: define TICK_GEN_FRAC_EN to add a per-channel fractional
// accumulator that stretches selected periods by one cycle, giving an average
// period of div + 1 + frac/2^FRAC_WIDTH. Without it cfg_frac is ignored and the
// frac field of rd_data reads 0.
module tick_gen #(
    parameter int unsigned          CHANNELS   = 4,
    parameter int unsigned          DIV_WIDTH  = 24,
    parameter int unsigned          FRAC_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DEF_DIV0   = DIV_WIDTH'(380),
    parameter logic [DIV_WIDTH-1:0] DEF_DIV1   = DIV_WIDTH'(216),
    parameter logic [CHANNELS-1:0]  DEF_EN     = CHANNELS'(4'b0011),
    localparam int unsigned         SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned         RD_W       = 1 + DIV_WIDTH + FRAC_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic                  cfg_en,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic [FRAC_WIDTH-1:0] cfg_frac,
    input  logic                  sync,
    output logic [RD_W-1:0]       rd_data,
    output logic [CHANNELS-1:0]   tick,
    output logic [CHANNELS-1:0]   tclk
);

    // Every select code that maps onto an existing channel.
    localparam int unsigned         SEL_SPAN  = 1 << SEL_W;
    localparam logic [SEL_SPAN-1:0] SEL_VALID = SEL_SPAN'((64'd1 << CHANNELS) - 64'd1);

    // Per-channel configuration and counting state.
    logic [CHANNELS-1:0]  en_q, en_d;
    logic [DIV_WIDTH-1:0] div_q [CHANNELS];
    logic [DIV_WIDTH-1:0] div_d [CHANNELS];
    logic [DIV_WIDTH-1:0] cnt_q [CHANNELS];
    logic [DIV_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CHANNELS-1:0]  tick_q, tick_d;
    logic [CHANNELS-1:0]  tclk_q, tclk_d;
    logic [RD_W-1:0]      rd_data_q, rd_data_d;

    logic                 sel_ok_c;
    logic [CHANNELS-1:0]  wr_hit_c;

`ifdef TICK_GEN_FRAC_EN
    // Fractional increment, phase accumulator and pending one-cycle stretch.
    logic [FRAC_WIDTH-1:0] frac_q [CHANNELS];
    logic [FRAC_WIDTH-1:0] frac_d [CHANNELS];
    logic [FRAC_WIDTH-1:0] acc_q  [CHANNELS];
    logic [FRAC_WIDTH-1:0] acc_d  [CHANNELS];
    logic [CHANNELS-1:0]   ext_q, ext_d;
    logic [FRAC_WIDTH:0]   acc_sum_c [CHANNELS];
`else
    logic                  unused_frac;
    assign unused_frac = ^cfg_frac;
`endif

    assign sel_ok_c = SEL_VALID[cfg_sel];

    // Decode which channel (if any) the current write targets.
    always_comb begin
        wr_hit_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit_c[i] = cfg_we && sel_ok_c && (cfg_sel == SEL_W'(i));
        end
    end

`ifdef TICK_GEN_FRAC_EN
    // Accumulator sum with carry out; carry stretches the following period.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            acc_sum_c[i] = {1'b0, acc_q[i]} + {1'b0, frac_q[i]};
        end
    end
`endif

    // Next-state: write beats disable beats sync beats normal counting.
    always_comb begin
        en_d      = en_q;
        tick_d    = '0;
        tclk_d    = tclk_q;
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
        end
`ifdef TICK_GEN_FRAC_EN
        ext_d = ext_q;
        for (int i = 0; i < CHANNELS; i++) begin
            frac_d[i] = frac_q[i];
            acc_d[i]  = acc_q[i];
        end
`endif

        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit_c[i]) begin
                en_d[i]  = cfg_en;
                div_d[i] = cfg_div;
                cnt_d[i] = '0;
`ifdef TICK_GEN_FRAC_EN
                frac_d[i] = cfg_frac;
                acc_d[i]  = '0;
                ext_d[i]  = 1'b0;
`endif
            end else if (!en_q[i]) begin
                cnt_d[i] = '0;
`ifdef TICK_GEN_FRAC_EN
                ext_d[i] = 1'b0;
`endif
            end else if (sync) begin
                cnt_d[i] = '0;
`ifdef TICK_GEN_FRAC_EN
                acc_d[i] = '0;
                ext_d[i] = 1'b0;
`endif
            end else if (cnt_q[i] == div_q[i]) begin
`ifdef TICK_GEN_FRAC_EN
                if (ext_q[i]) begin
                    // Hold at terminal count for one extra cycle.
                    ext_d[i] = 1'b0;
                end else begin
                    tick_d[i] = 1'b1;
                    tclk_d[i] = ~tclk_q[i];
                    cnt_d[i]  = '0;
                    acc_d[i]  = acc_sum_c[i][FRAC_WIDTH-1:0];
                    ext_d[i]  = acc_sum_c[i][FRAC_WIDTH];
                end
`else
                tick_d[i] = 1'b1;
                tclk_d[i] = ~tclk_q[i];
                cnt_d[i]  = '0;
`endif
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
            end
        end

        // Readback uses next-state so a write is visible on the following cycle.
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_ok_c && (cfg_sel == SEL_W'(i))) begin
`ifdef TICK_GEN_FRAC_EN
                rd_data_d = {en_d[i], div_d[i], frac_d[i]};
`else
                rd_data_d = {en_d[i], div_d[i], FRAC_WIDTH'(0)};
`endif
            end
        end
    end

    // State registers with synchronous reset to the power-on configuration.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q      <= DEF_EN;
            tick_q    <= '0;
            tclk_q    <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (i == 0) begin
                    div_q[i] <= DEF_DIV0;
                end else if (i == 1) begin
                    div_q[i] <= DEF_DIV1;
                end else begin
                    div_q[i] <= '0;
                end
                cnt_q[i] <= '0;
            end
`ifdef TICK_GEN_FRAC_EN
            ext_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                frac_q[i] <= '0;
                acc_q[i]  <= '0;
            end
`endif
        end else begin
            en_q      <= en_d;
            tick_q    <= tick_d;
            tclk_q    <= tclk_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
`ifdef TICK_GEN_FRAC_EN
            ext_q <= ext_d;
            for (int i = 0; i < CHANNELS; i++) begin
                frac_q[i] <= frac_d[i];
                acc_q[i]  <= acc_d[i];
            end
`endif
        end
    end

    assign rd_data = rd_data_q;
    assign tick    = tick_q;
    assign tclk    = tclk_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen. Expected tick edges are queued per
// channel when stimulus is applied and matched against observed ticks; expected
// readback words are queued on each select change and popped a cycle later.
`timescale 1ns/1ps
module tb_tick_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 24;
    localparam int unsigned FW = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned RW = 1 + DW + FW;
`ifdef TICK_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [SW-1:0] cfg_sel;
    logic          cfg_en;
    logic [DW-1:0] cfg_div;
    logic [FW-1:0] cfg_frac;
    logic          sync;
    logic [RW-1:0] rd_data;
    logic [CH-1:0] tick;
    logic [CH-1:0] tclk;

    int unsigned   edge_n = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    int unsigned   exp_q [CH][$];
    logic [RW-1:0] rd_q [$];
    logic [CH-1:0] mon_en;
    logic [CH-1:0] tclk_known;
    logic [CH-1:0] exp_tclk;

    tick_gen dut (
        .clock   (clk),
        .reset   (reset),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_en  (cfg_en),
        .cfg_div (cfg_div),
        .cfg_frac(cfg_frac),
        .sync    (sync),
        .rd_data (rd_data),
        .tick    (tick),
        .tclk    (tclk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [RW-1:0] rd_word(input logic en, input logic [DW-1:0] div,
                                              input logic [FW-1:0] frac);
        return {en, div, (FRAC_ON ? frac : FW'(0))};
    endfunction

    // All tasks below are entered and left on a falling clock edge.
    task automatic wait_to(input int unsigned n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic cfg_write(input int unsigned ch, input logic en, input logic [DW-1:0] div,
                             input logic [FW-1:0] frac, output int unsigned w);
        logic [RW-1:0] e;
        cfg_we   = 1'b1;
        cfg_sel  = SW'(ch);
        cfg_en   = en;
        cfg_div  = div;
        cfg_frac = frac;
        w        = edge_n + 1;
        rd_q.push_back(rd_word(en, div, frac));
        @(negedge clk);
        cfg_we = 1'b0;
        e = rd_q.pop_front();
        check_val($sformatf("wr_readback_ch%0d", ch), 64'(rd_data), 64'(e));
    endtask

    task automatic set_sel(input int unsigned ch, input logic [RW-1:0] exp);
        logic [RW-1:0] e;
        cfg_sel = SW'(ch);
        rd_q.push_back(exp);
        @(negedge clk);
        e = rd_q.pop_front();
        check_val($sformatf("readback_ch%0d", ch), 64'(rd_data), 64'(e));
    endtask

    task automatic do_sync(output int unsigned s);
        sync = 1'b1;
        s    = edge_n + 1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    // Tick monitor: match each observed tick against the head of its queue.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            if (mon_en[c]) begin
                while (exp_q[c].size() > 0 && exp_q[c][0] < edge_n) begin
                    check_val($sformatf("tick%0d_missed_at_%0d", c, exp_q[c][0]), 64'(0), 64'(1));
                    void'(exp_q[c].pop_front());
                end
                if (tick[c]) begin
                    int unsigned want;
                    want = (exp_q[c].size() > 0) ? exp_q[c][0] : 0;
                    check_val($sformatf("tick%0d_edge", c), 64'(edge_n), 64'(want));
                    if (want == edge_n) begin
                        void'(exp_q[c].pop_front());
                        exp_tclk[c] = ~exp_tclk[c];
                        if (tclk_known[c]) begin
                            check_val($sformatf("tclk%0d", c), 64'(tclk[c]), 64'(exp_tclk[c]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r, w, s, t;

        reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0;
        cfg_div = '0; cfg_frac = '0; sync = 1'b0;
        mon_en = '0; tclk_known = '0; exp_tclk = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_val("rst_tick", 64'(tick), 64'(0));
        check_val("rst_tclk", 64'(tclk), 64'(0));
        check_val("rst_rd_data", 64'(rd_data), 64'(0));

        // Free run from reset: ch0 every 381, ch1 every 217, ch2/ch3 silent.
        reset = 1'b0;
        r = edge_n;
        for (int k = 1; k <= 5; k++) exp_q[0].push_back(r + 381 * k);
        for (int k = 1; k <= 9; k++) exp_q[1].push_back(r + 217 * k);
        mon_en = '1; tclk_known = '1; exp_tclk = '0;
        set_sel(0, rd_word(1'b1, DW'(380), FW'(0)));
        set_sel(1, rd_word(1'b1, DW'(216), FW'(0)));
        set_sel(2, rd_word(1'b0, DW'(0), FW'(0)));
        wait_to(r + 2000);
        check_val("p1_q0_left", 64'(exp_q[0].size()), 64'(0));
        check_val("p1_q1_left", 64'(exp_q[1].size()), 64'(0));
        check_val("p1_tclk0", 64'(tclk[0]), 64'(1));
        check_val("p1_tclk23", 64'(tclk[3:2]), 64'(0));
        mon_en[0] = 1'b0; mon_en[1] = 1'b0;

        // ch2 div=0: tick every cycle; then disable and check tclk holds.
        cfg_write(2, 1'b1, DW'(0), FW'(0), w);
        for (int k = 1; k <= 11; k++) exp_q[2].push_back(w + k);
        wait_to(w + 11);
        cfg_write(2, 1'b0, DW'(0), FW'(0), t);
        repeat (3) @(negedge clk);
        check_val("p2_q2_left", 64'(exp_q[2].size()), 64'(0));
        check_val("p2_tclk2_hold", 64'(tclk[2]), 64'(exp_tclk[2]));
        check_val("p2_tick2_off", 64'(tick[2]), 64'(0));

        // ch3 div=9, sync 25 cycles after the write restarts its phase.
        cfg_write(3, 1'b1, DW'(9), FW'(8'h5A), w);
        exp_q[3].push_back(w + 10);
        exp_q[3].push_back(w + 20);
        wait_to(w + 24);
        do_sync(s);
        check_val("p3_sync_edge", 64'(s), 64'(w + 25));
        exp_q[3].push_back(s + 10);
        exp_q[3].push_back(s + 20);
        wait_to(s + 20);
        cfg_write(3, 1'b0, DW'(9), FW'(0), t);
        check_val("p3_q3_left", 64'(exp_q[3].size()), 64'(0));

        // Rewrite ch1 while its counter is at 150 (phase set by the sync above).
        w = s + 151;
        while (w < edge_n + 2) w = w + 217;
        wait_to(w - 1);
        cfg_write(1, 1'b1, DW'(216), FW'(0), t);
        check_val("p4_write_edge", 64'(t), 64'(w));
        exp_q[1].push_back(w + 217);
        exp_q[1].push_back(w + 434);
        tclk_known[1] = 1'b0;
        mon_en[1] = 1'b1;
        wait_to(w + 434);
        check_val("p4_q1_left", 64'(exp_q[1].size()), 64'(0));
        mon_en = '0;

        // One-cycle reset mid-period restores defaults and restarts phases.
        reset = 1'b1;
        r = edge_n + 1;
        @(negedge clk);
        reset = 1'b0;
        check_val("p5_tick", 64'(tick), 64'(0));
        check_val("p5_tclk", 64'(tclk), 64'(0));
        check_val("p5_rd_data", 64'(rd_data), 64'(0));
        exp_tclk = '0; tclk_known = '1;
        exp_q[0].push_back(r + 381);
        exp_q[0].push_back(r + 762);
        for (int k = 1; k <= 3; k++) exp_q[1].push_back(r + 217 * k);
        mon_en = '1;
        set_sel(0, rd_word(1'b1, DW'(380), FW'(0)));
        set_sel(1, rd_word(1'b1, DW'(216), FW'(0)));
        set_sel(3, rd_word(1'b0, DW'(0), FW'(0)));
        wait_to(r + 762);
        check_val("p5_q0_left", 64'(exp_q[0].size()), 64'(0));
        check_val("p5_q1_left", 64'(exp_q[1].size()), 64'(0));
        mon_en[0] = 1'b0; mon_en[1] = 1'b0;

`ifdef TICK_GEN_FRAC_EN
        // frac=2/256: the 129th tick of 128 periods lands after 27777 cycles.
        cfg_write(1, 1'b1, DW'(216), FW'(8'h02), w);
        t = w;
        for (int k = 1; k <= 128; k++) begin
            t = t + 217;
            exp_q[1].push_back(t);
        end
        exp_q[1].push_back(t + 218);
        check_val("p6_span", 64'((t + 218) - (w + 217)), 64'(27777));
        tclk_known[1] = 1'b0;
        mon_en[1] = 1'b1;
        wait_to(t + 218);
        check_val("p6_q1_left", 64'(exp_q[1].size()), 64'(0));
        mon_en[1] = 1'b0;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
